// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if
//   Handshake and strobe bundle between the multi-cycle sequencing
//   controller and the RV32I datapath / memory ports.
//
//   inst        IR contents, valid from DECODE onward     (datapath -> ctrl)
//   imem_req    instruction fetch request                 (ctrl -> imem)
//   imem_ready  fetch data valid this cycle               (imem -> ctrl)
//   dmem_req    data access request                       (ctrl -> dmem)
//   dmem_we     data access is a store, with dmem_req     (ctrl -> dmem)
//   dmem_ready  data access complete this cycle           (dmem -> ctrl)
//   ir_we       capture fetched word into IR              (ctrl -> datapath)
//   ex_we       latch Alu_Out / PC_IN                     (ctrl -> datapath)
//   rf_we       register-file write strobe                (ctrl -> datapath)
//   wb_sel      0 ALU, 1 load data, 2 PC+4, 3 immediate   (ctrl -> datapath)
//   pc_we       load PC from latched PC_IN                (ctrl -> datapath)
interface mc_ctrl_if;
  logic [31:0] inst;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        ir_we;
  logic        ex_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;

  // Controller side
  modport master (
    input  inst, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, ex_we, rf_we, wb_sel, pc_we
  );

  // Datapath / memory side
  modport slave (
    output inst, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, ex_we, rf_we, wb_sel, pc_we
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl
//   Multi-cycle sequencing controller for the RV32I core. Steps each
//   instruction through FETCH, DECODE, EXEC, (MEM), WB and issues the
//   memory handshakes and datapath write strobes. Owns the retired
//   instruction counter and the halt / illegal status.
//
//   clk      core clock, rising edge
//   rst      synchronous active-high reset; forces all strobes low
//   bus      mc_ctrl_if.master handshake / strobe bundle
//   state    current state encoding (FETCH=0 .. HALT=5)
//   halted   controller is in HALT
//   illegal  sticky: halt caused by an undecodable instruction
//   instret  retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_if.master        bus,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IOP    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t           state_reg, state_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] instret_reg;

  // Instruction class decode from the latched IR
  logic [6:0] opcode;
  logic       is_load, is_store, is_jump, is_lui, is_alu, is_system, is_legal;
  logic       writes_rd;
  logic [1:0] sel_class;

  assign opcode    = bus.inst[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_alu    = (opcode == OP_R) || (opcode == OP_IOP) || (opcode == OP_AUIPC);
  assign is_system = (opcode == OP_SYSTEM);
  assign is_legal  = (bus.inst[1:0] == 2'b11) &&
                     (is_load || is_store || is_jump || is_lui || is_alu ||
                      (opcode == OP_BRANCH) || (opcode == OP_FENCE));
  // Store, branch and fence never write; rd=x0 suppresses the strobe too
  assign writes_rd = (is_alu || is_load || is_jump || is_lui) && (bus.inst[11:7] != 5'd0);
  assign sel_class = is_load ? 2'd1 : is_jump ? 2'd2 : is_lui ? 2'd3 : 2'd0;

  // Upper immediate / register fields are consumed by the datapath only
  logic unused_inst_bits;
  assign unused_inst_bits = ^bus.inst[31:12];

  // Moore strobes before reset gating
  logic       imem_req_c, dmem_req_c, dmem_we_c;
  logic       ir_we_c, ex_we_c, rf_we_c, pc_we_c;
  logic [1:0] wb_sel_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (state_reg == WB) begin
        instret_reg <= instret_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    ir_we_c      = 1'b0;
    ex_we_c      = 1'b0;
    rf_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    wb_sel_c     = 2'd0;
    case (state_reg)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_we_c    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // SYSTEM is checked first: it is a clean halt, not an illegal one
        if (is_system) begin
          state_next   = HALT;
          illegal_next = 1'b0;
        end else if (!is_legal) begin
          state_next   = HALT;
          illegal_next = 1'b1;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        ex_we_c    = 1'b1;
        state_next = (is_load || is_store) ? MEM : WB;
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (bus.dmem_ready) begin
          state_next = WB;
        end
      end
      WB: begin
        pc_we_c    = 1'b1;
        rf_we_c    = writes_rd;
        wb_sel_c   = writes_rd ? sel_class : 2'd0;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        // Unused encodings are treated as a corrupted sequence
        state_next   = HALT;
        illegal_next = 1'b1;
      end
    endcase
  end

  // Reset drops every strobe in the same cycle, including an open request
  assign bus.imem_req = imem_req_c & ~rst;
  assign bus.dmem_req = dmem_req_c & ~rst;
  assign bus.dmem_we  = dmem_we_c  & ~rst;
  assign bus.ir_we    = ir_we_c    & ~rst;
  assign bus.ex_we    = ex_we_c    & ~rst;
  assign bus.rf_we    = rf_we_c    & ~rst;
  assign bus.pc_we    = pc_we_c    & ~rst;
  assign bus.wb_sel   = rst ? 2'd0 : wb_sel_c;

  assign state   = state_reg;
  assign halted  = (state_reg == HALT);
  assign illegal = illegal_reg;
  assign instret = instret_reg;

endmodule
